vertex_transform_stream: RTL and testbench
==========================================

Name: vertex_transform_stream

Overview:
- Downstream consumer of the 4x4 matrix multiplier: takes a composed 128-bit transform matrix and applies it to a stream of 4-element homogeneous vertices (out = M * v).
- Two-stage pipelined datapath with valid/ready handshakes on the matrix-load, vertex-in and vertex-out interfaces.
- Sits between the matrix compose stage and the rasteriser front end.

Parameters:
- ELEM_W, 8, width of one matrix/vector element (unsigned).
- CNT_W, 16, width of the transformed-vertex counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mat_in  input  16*ELEM_W  matrix, row-major; element [0][0] in the top ELEM_W bits, [3][3] in the bottom bits.
- mat_valid  input  1  mat_in is valid.
- mat_ready  output  1  block can accept a matrix load.
- vtx_in  input  4*ELEM_W  vertex {x,y,z,w}; x in the top ELEM_W bits.
- vtx_valid  input  1  vtx_in is valid.
- vtx_ready  output  1  block accepts vtx_in this cycle.
- vtx_out  output  4*ELEM_W  transformed vertex {x',y',z',w'}, same packing as vtx_in.
- out_valid  output  1  vtx_out is valid.
- out_ready  input  1  downstream accepts vtx_out.
- vtx_count  output  CNT_W  vertices emitted since the last matrix load or reset.

Behaviour:
- Reset values:
  - Matrix register = identity (diagonal elements 1, all others 0).
  - s1_valid = 0; out_valid = 0; vtx_out = 0; vtx_count = 0.
- Reset mid-operation discards in-flight vertices.
- Arithmetic:
  - Products are 2*ELEM_W bits; each row sum of 4 products is 2*ELEM_W+2 bits.
  - Output element = row sum modulo 2^ELEM_W (low ELEM_W bits), matching the upstream matmul wrap semantics.
- Pipeline stages:
  - Stage 1 registers all 16 products and s1_valid.
  - Stage 2 registers the four sums (truncated) into vtx_out and sets out_valid.
- Latency: exactly 2 cycles from vtx handshake to out_valid, given out_ready stays high. Throughput is 1 vertex per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - vtx_ready = s1_adv && !(mat_valid && mat_ready).
  - Stalled stages hold their data; vtx_out is stable while out_valid && !out_ready.
- Matrix load:
  - mat_ready = !s1_valid && !out_valid (pipeline empty). A matrix is never swapped under in-flight vertices.
  - On a mat_valid && mat_ready cycle: the matrix register is loaded and vtx_count is cleared.
  - Same cycle as vtx_valid: the matrix wins and the vertex is not accepted (vtx_ready = 0).
  - Vertices accepted after the load use the new matrix.
- Counter:
  - vtx_count increments on each out_valid && out_ready cycle and wraps from 2^CNT_W-1 to 0.
  - A matrix load coinciding with an output handshake cannot occur, because mat_ready requires out_valid = 0.
- Blocking: with continuous vtx_valid traffic, mat_ready stays low. The upstream block must deassert vtx_valid to load a new matrix.

Optional Feature:
- Macro: VTX_SATURATE_EN.
- Defined: each output element saturates to 2^ELEM_W-1 when the row sum exceeds that value.
- Undefined: each output element wraps modulo 2^ELEM_W (default).
- Latency and handshakes are identical in both builds.

Decomposition:
- Shared package gfx_pkg:
  - ELEM_W default.
  - MAT_W = 16*ELEM_W.
  - VEC_W = 4*ELEM_W.
  - IDENTITY_MAT constant.
  - Typedef for an element and a sum-width word.
- One sub-module, dot4_row: takes four registered products and produces the wrapped or saturated ELEM_W result. It is instantiated four times in stage 2.

Test Plan:
- Reset, then send vtx_in = {8'd3, 8'd5, 8'd7, 8'd1} with identity matrix -> exactly 2 cycles later vtx_out = {3,5,7,1}, out_valid = 1, vtx_count = 1.
- Load matrix with all elements 2, then send v = {1,2,3,4} -> each output element = 20 (0x14).
- Load matrix with all elements 0xFF, send v = {0xFF,0xFF,0xFF,0xFF} -> row sum 0x3F804; vtx_out elements 0x04, or 0xFF with VTX_SATURATE_EN.
- Stream 8 back-to-back vertices with out_ready toggled 1,0,0,1,... -> no loss or duplication; vtx_out holds stable during stalls; final vtx_count = 8.
- Drive mat_valid and vtx_valid together on an empty pipe -> mat_ready = 1, vtx_ready = 0; the matrix loads and vtx_count = 0. A matrix offered while out_valid = 1 -> mat_ready = 0 until drained.
- Assert rst while 2 vertices are in flight -> next cycle out_valid = 0, vtx_count = 0, and the matrix reads back as identity on the next vertex.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline constants and types: element/vector/matrix widths,
// the identity matrix constant and the sum-width word used by the row reducers.
package gfx_pkg;

    localparam int ELEM_W = 8;
    localparam int CNT_W  = 16;
    localparam int MAT_W  = 16 * ELEM_W;
    localparam int VEC_W  = 4 * ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int SUM_W  = 2 * ELEM_W + 2;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [SUM_W-1:0]  sum_t;

    // Element k = row*4+col sits at bits [(15-k)*ELEM_W +: ELEM_W]; diagonal is k%5==0.
    function automatic logic [MAT_W-1:0] identity_mat();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            if (k % 5 == 0) begin
                m[(15-k)*ELEM_W +: ELEM_W] = elem_t'(1);
            end
        end
        return m;
    endfunction

    localparam logic [MAT_W-1:0] IDENTITY_MAT = identity_mat();

endpackage

// File: rtl/vertex_transform_stream_if.sv
// Matrix-load, vertex-in and vertex-out handshake bundle for vertex_transform_stream.
// master = upstream/downstream side, slave = the transform block.
interface vertex_transform_stream_if #(
    parameter int ELEM_W = gfx_pkg::ELEM_W,
    parameter int CNT_W  = gfx_pkg::CNT_W
);
    logic [16*ELEM_W-1:0] mat_in;
    logic                 mat_valid;
    logic                 mat_ready;
    logic [4*ELEM_W-1:0]  vtx_in;
    logic                 vtx_valid;
    logic                 vtx_ready;
    logic [4*ELEM_W-1:0]  vtx_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     vtx_count;

    modport master (
        output mat_in, mat_valid, vtx_in, vtx_valid, out_ready,
        input  mat_ready, vtx_ready, vtx_out, out_valid, vtx_count
    );

    modport slave (
        input  mat_in, mat_valid, vtx_in, vtx_valid, out_ready,
        output mat_ready, vtx_ready, vtx_out, out_valid, vtx_count
    );

endinterface

// File: rtl/vertex_transform_stream_dot4_row.sv
// dot4_row: reduces four registered products to one output element.
// Wraps modulo 2^ELEM_W by default; saturates when VTX_SATURATE_EN is defined.
module dot4_row #(
    parameter int ELEM_W = gfx_pkg::ELEM_W
) (
    input  logic [2*ELEM_W-1:0] p0,
    input  logic [2*ELEM_W-1:0] p1,
    input  logic [2*ELEM_W-1:0] p2,
    input  logic [2*ELEM_W-1:0] p3,
    output logic [ELEM_W-1:0]   res
);
    localparam int S_W = 2 * ELEM_W + 2;

    logic [S_W-1:0] sum;

    assign sum = S_W'(p0) + S_W'(p1) + S_W'(p2) + S_W'(p3);

`ifdef VTX_SATURATE_EN
    assign res = (|sum[S_W-1:ELEM_W]) ? '1 : sum[ELEM_W-1:0];
`else
    // Upper sum bits are intentionally discarded to match upstream wrap semantics.
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[S_W-1:ELEM_W];
    assign res           = sum[ELEM_W-1:0];
`endif

endmodule

// File: rtl/vertex_transform_stream.sv
// Applies a loaded 4x4 matrix to a stream of homogeneous vertices (out = M * v)
// in a two-stage pipeline. Output saturation is selected by VTX_SATURATE_EN.
module vertex_transform_stream #(
    parameter int ELEM_W = gfx_pkg::ELEM_W,
    parameter int CNT_W  = gfx_pkg::CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    vertex_transform_stream_if.slave bus
);
    import gfx_pkg::*;

    localparam int M_W = 16 * ELEM_W;
    localparam int V_W = 4 * ELEM_W;
    localparam int P_W = 2 * ELEM_W;

    logic [M_W-1:0]   mat_q, mat_d, mat_ident;
    logic [P_W-1:0]   prod_q [16];
    logic [P_W-1:0]   prod_d [16];
    logic [P_W-1:0]   prod_mul [16];
    logic             s1_valid_q, s1_valid_d;
    logic [V_W-1:0]   vtx_out_q, vtx_out_d, row_res;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s1_adv, s2_adv, mat_ready, vtx_ready, mat_fire, vtx_fire, out_fire;

    // Stage 1 products: element k = row*4+col multiplies vertex component col.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_prod
            assign mat_ident[(15-gi)*ELEM_W +: ELEM_W] = (gi % 5 == 0) ? ELEM_W'(1) : '0;
            assign prod_mul[gi] = P_W'(mat_q[(15-gi)*ELEM_W +: ELEM_W])
                                * P_W'(bus.vtx_in[(3-(gi%4))*ELEM_W +: ELEM_W]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            dot4_row #(.ELEM_W(ELEM_W)) u_row (
                .p0  (prod_q[gi*4+0]),
                .p1  (prod_q[gi*4+1]),
                .p2  (prod_q[gi*4+2]),
                .p3  (prod_q[gi*4+3]),
                .res (row_res[(3-gi)*ELEM_W +: ELEM_W])
            );
        end
    endgenerate

    // Matrix loads only into an empty pipe, so no in-flight vertex sees a swap.
    assign s2_adv    = !out_valid_q || bus.out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign mat_ready = !s1_valid_q && !out_valid_q;
    assign mat_fire  = bus.mat_valid && mat_ready;
    assign vtx_ready = s1_adv && !mat_fire;
    assign vtx_fire  = bus.vtx_valid && vtx_ready;
    assign out_fire  = out_valid_q && bus.out_ready;

    always_comb begin
        mat_d       = mat_q;
        prod_d      = prod_q;
        s1_valid_d  = s1_valid_q;
        vtx_out_d   = vtx_out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (mat_fire) begin
            mat_d = bus.mat_in;
        end

        if (s1_adv) begin
            s1_valid_d = vtx_fire;
            if (vtx_fire) begin
                prod_d = prod_mul;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                vtx_out_d = row_res;
            end
        end

        if (mat_fire) begin
            cnt_d = '0;
        end else if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q       <= mat_ident;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            vtx_out_q   <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            mat_q       <= mat_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            vtx_out_q   <= vtx_out_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
        end
    end

    assign bus.mat_ready = mat_ready;
    assign bus.vtx_ready = vtx_ready;
    assign bus.vtx_out   = vtx_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.vtx_count = cnt_q;

endmodule

// File: tb/tb_vertex_transform_stream.sv
// Directed bench for vertex_transform_stream: a queue-based transaction model
// checked every cycle, plus hand-computed literal expectations.
module tb_vertex_transform_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vertex_transform_stream_if #(.ELEM_W(8), .CNT_W(16)) bus ();

    vertex_transform_stream #(.ELEM_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] val;
        int          acc;
    } exp_t;

    exp_t         q[$];
    logic [127:0] mdl_mat;
    logic [15:0]  mdl_cnt;
    logic [31:0]  last_out;
    int           n_out   = 0;
    int           cyc     = 0;
    int           n_pass  = 0;
    int           n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference transform from plain integer arithmetic.
    function automatic logic [31:0] model_xform(input logic [127:0] m, input logic [31:0] v);
        logic [31:0] r;
        int          s;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            s = 0;
            for (int c = 0; c < 4; c++) begin
                s += int'(m[127-8*(row*4+c) -: 8]) * int'(v[31-8*c -: 8]);
            end
`ifdef VTX_SATURATE_EN
            r[31-8*row -: 8] = (s > 255) ? 8'hFF : s[7:0];
`else
            r[31-8*row -: 8] = s[7:0];
`endif
        end
        return r;
    endfunction

    // Compare process: checks DUT against the transaction model, then applies
    // the handshakes that will take effect at the coming rising edge.
    always @(negedge clk) begin
        int   n;
        logic exp_ov;
        if (rst) begin
            q.delete();
            mdl_mat = gfx_pkg::IDENTITY_MAT;
            mdl_cnt = '0;
        end else begin
            n      = q.size();
            exp_ov = (n > 0) && (cyc >= q[0].acc + 2);
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov && bus.out_valid) begin
                chk("vtx_out", 64'(bus.vtx_out), 64'(q[0].val));
            end
            chk("vtx_count", 64'(bus.vtx_count), 64'(mdl_cnt));
            chk("mat_ready", 64'(bus.mat_ready), 64'(n == 0));
            chk("vtx_ready", 64'(bus.vtx_ready),
                64'(!(bus.mat_valid && n == 0) && !(n == 2 && !bus.out_ready)));
            if (bus.mat_valid && bus.mat_ready) begin
                mdl_mat = bus.mat_in;
                mdl_cnt = '0;
            end
            if (bus.out_valid && bus.out_ready && n > 0) begin
                last_out = bus.vtx_out;
                n_out++;
                void'(q.pop_front());
                mdl_cnt++;
            end
            if (bus.vtx_valid && bus.vtx_ready) begin
                q.push_back('{val: model_xform(mdl_mat, bus.vtx_in), acc: cyc});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vtx(input logic [31:0] v);
        logic ok;
        ok = 1'b0;
        bus.vtx_in    = v;
        bus.vtx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.vtx_ready;
            tick();
        end
        if (!ok) chk("vtx_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic load_mat(input logic [127:0] m);
        logic ok;
        ok = 1'b0;
        bus.mat_in    = m;
        bus.mat_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.mat_ready;
            tick();
        end
        bus.mat_valid = 1'b0;
        if (!ok) chk("mat_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        logic done;
        done          = 1'b0;
        bus.vtx_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = !bus.out_valid && (q.size() == 0);
            tick();
        end
        if (!done) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [31:0] stream_vec(input int i);
        return {8'(i + 1), 8'(2 * i), 8'd3, 8'(255 - i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] m;
        logic         acc;
        int           idx;
        int           out_base;

        bus.mat_in    = '0;
        bus.mat_valid = 1'b0;
        bus.vtx_in    = '0;
        bus.vtx_valid = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_vtx_out",   64'(bus.vtx_out),   64'(0));
        chk("rst_count",     64'(bus.vtx_count), 64'(0));
        chk("rst_mat_ready", 64'(bus.mat_ready), 64'(1));
        tick();

        // Identity matrix, exact two-cycle latency
        send_vtx(32'h03050701);
        bus.vtx_valid = 1'b0;
        @(negedge clk);
        chk("lat1_out_valid", 64'(bus.out_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("lat2_out_valid", 64'(bus.out_valid), 64'(1));
        chk("ident_vtx_out",  64'(bus.vtx_out),   64'(32'h03050701));
        tick();
        @(negedge clk);
        chk("ident_count",    64'(bus.vtx_count), 64'(1));
        drain();

        // All-2 matrix: each element 2*(1+2+3+4) = 20
        m = {16{8'h02}};
        load_mat(m);
        send_vtx(32'h01020304);
        drain();
        chk("twos_vtx_out", 64'(last_out), 64'(32'h14141414));

        // All-FF matrix and vertex: row sum 0x3F804
        m = {16{8'hFF}};
        load_mat(m);
        send_vtx(32'hFFFFFFFF);
        drain();
`ifdef VTX_SATURATE_EN
        chk("ff_vtx_out", 64'(last_out), 64'(32'hFFFFFFFF));
`else
        chk("ff_vtx_out", 64'(last_out), 64'(32'h04040404));
`endif
        chk("ff_count", 64'(bus.vtx_count), 64'(1));

        // Eight back-to-back vertices with out_ready pattern 1,0,0
        m = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        load_mat(m);
        out_base      = n_out;
        idx           = 0;
        bus.vtx_in    = stream_vec(0);
        bus.vtx_valid = 1'b1;
        for (int t = 0; t < 200 && idx < 8; t++) begin
            bus.out_ready = (t % 3 == 0);
            @(negedge clk);
            acc = bus.vtx_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 8) bus.vtx_in = stream_vec(idx);
                else bus.vtx_valid = 1'b0;
            end
        end
        drain();
        chk("stream_sent",  64'(idx),              64'(8));
        chk("stream_nout",  64'(n_out - out_base), 64'(8));
        chk("stream_count", 64'(bus.vtx_count),    64'(8));

        // Matrix and vertex offered together on an empty pipe: matrix wins
        bus.out_ready = 1'b0;
        bus.mat_in    = 128'h02000000_00020000_00000200_00000002;
        bus.mat_valid = 1'b1;
        bus.vtx_in    = 32'h01020304;
        bus.vtx_valid = 1'b1;
        @(negedge clk);
        chk("both_mat_ready", 64'(bus.mat_ready), 64'(1));
        chk("both_vtx_ready", 64'(bus.vtx_ready), 64'(0));
        tick();
        bus.mat_valid = 1'b0;
        @(negedge clk);
        chk("load_count_clear", 64'(bus.vtx_count), 64'(0));
        chk("after_load_vtx_ready", 64'(bus.vtx_ready), 64'(1));
        tick();
        bus.vtx_valid = 1'b0;
        // Matrix offered while an output is pending must wait for the drain
        bus.mat_in    = {16{8'h01}};
        bus.mat_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("busy_mat_ready", 64'(bus.mat_ready), 64'(0));
            tick();
        end
        chk("stall_vtx_out", 64'(bus.vtx_out), 64'(32'h02040608));
        bus.out_ready = 1'b1;
        load_mat({16{8'h01}});
        chk("scaled_vtx_out", 64'(last_out), 64'(32'h02040608));
        @(negedge clk);
        chk("reload_count", 64'(bus.vtx_count), 64'(0));
        tick();

        // Reset with two vertices in flight
        bus.out_ready = 1'b0;
        send_vtx(32'h01010101);
        send_vtx(32'h02020202);
        bus.vtx_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_count",     64'(bus.vtx_count), 64'(0));
        chk("midrst_mat_ready", 64'(bus.mat_ready), 64'(1));
        tick();
        bus.out_ready = 1'b1;
        send_vtx(32'h09080706);
        drain();
        chk("midrst_identity", 64'(last_out), 64'(32'h09080706));
        chk("model_pin_ones", 64'(model_xform({16{8'h01}}, 32'h09080706)), 64'(32'h1E1E1E1E));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
